// File: rtl/qeciphy_pkg.sv
// Shared QECIPHY definitions: frame type encodings, the ALIGN payload and
// the TX scheduler state encoding. Used by the TX scheduler, the channel
// encoder and the RX decoder so all three agree on the wire format.
package qeciphy_pkg;

    // Two-bit frame type carried alongside every 64-bit frame payload.
    typedef enum logic [1:0] {
        FT_IDLE   = 2'b00,
        FT_DATA   = 2'b01,
        FT_STATUS = 2'b10,
        FT_ALIGN  = 2'b11
    } frame_type_e;

    // Fixed ALIGN pattern; rich in transitions so the far end can lock on it.
    localparam logic [63:0] ALIGN_WORD = 64'hBC5A_3CC3_A55A_BC3C;

    // Link bring-up / power-down sequencing states of the TX scheduler.
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_PD_WAIT = 2'd2,
        ST_PD_IDLE = 2'd3
    } tx_state_e;

    // STATUS payload: {pd_ack, pd_req, rx_rdy} in the low bits, rest zero.
    function automatic logic [63:0] status_payload(input logic [2:0] triple);
        return {61'h0, triple};
    endfunction

endpackage

// File: rtl/qeciphy_period_counter.sv
// Saturating period counter. Counts increment strobes up to PERIOD-1 and
// holds there, flagging `due_o`, until cleared. Clear wins over increment.
module qeciphy_period_counter #(
    parameter int PERIOD = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic due_o
);

    localparam int              W       = $clog2(PERIOD);
    localparam logic [W-1:0]    DUE_VAL = W'(PERIOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign due_o = (count_q == DUE_VAL);

    // Next count: clear, else step unless already saturated at the due value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !due_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/qeciphy_tx_scheduler.sv
// QECIPHY TX frame scheduler. Chooses, for each output slot, one of STATUS,
// ALIGN, DATA (from the TX FIFO) or IDLE, and sequences link bring-up and
// power-down. One register stage between the FIFO and the encoder.
//
// Handshakes:
//   FIFO side    - a word moves when i_valid && o_ready at a rising edge;
//                  o_ready never depends on o_ready-side state beyond this
//                  cycle and is only high when the word is actually loaded.
//   Encoder side - a frame moves when o_frame_valid && i_frame_ready at a
//                  rising edge; the output register only reloads when it is
//                  empty or its current frame is being accepted, so a frame
//                  is held stable while i_frame_ready is low.
module qeciphy_tx_scheduler
    import qeciphy_pkg::*;
#(
    parameter int ALIGN_PERIOD  = 1024,
    parameter int STATUS_REPEAT = 64
) (
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic        i_rx_rdy,
    input  logic        i_remote_rx_rdy,
    input  logic        i_pd_req,
    input  logic        i_pd_ack,
    input  logic [63:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_allow_user_tx,
    output logic [63:0] o_frame_data,
    output logic [1:0]  o_frame_type,
    output logic        o_frame_valid,
    input  logic        i_frame_ready,
    output logic [1:0]  o_dbg_state
);

    tx_state_e   state_q;
    tx_state_e   state_d;
    frame_type_e sel;
    frame_type_e type_q;
    logic [63:0] data_q;
    logic [63:0] payload;
    logic        valid_q;
    logic        allow_q;
    logic [2:0]  last_q;
    logic [2:0]  status_now;
    logic        pending_q;
    logic        pending_d;
    logic        load;
    logic        link_up;
    logic        status_diff;
    logic        status_pend;
    logic        align_due;
    logic        status_due;
    logic        pd_rise;
    logic        enter_active;
    logic        align_clr;
    logic        status_clr;
    logic        cnt_inc;

    assign load        = !valid_q || i_frame_ready;
    assign link_up     = i_rx_rdy && i_remote_rx_rdy;
    assign status_now  = {i_pd_ack, i_pd_req, i_rx_rdy};
    assign status_diff = (status_now != last_q);
    assign status_pend = pending_q || status_diff || status_due;
    // Compared against what the far end was last told, not the previous cycle.
    assign pd_rise     = i_pd_req && !last_q[1];

    // Slot selection and next state; state only advances on load cycles,
    // except a link drop in ACTIVE which is taken immediately.
    always_comb begin
        state_d = state_q;
        sel     = FT_IDLE;
        unique case (state_q)
            ST_INIT: begin
                sel = FT_ALIGN;
                if (load && link_up) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!link_up) begin
                    sel     = FT_ALIGN;
                    state_d = ST_INIT;
                end else begin
                    if (status_pend) begin
                        sel = FT_STATUS;
                    end else if (align_due) begin
                        sel = FT_ALIGN;
                    end else if (i_valid) begin
                        sel = FT_DATA;
                    end else begin
                        sel = FT_IDLE;
                    end
                    if (load && pd_rise) begin
                        state_d = ST_PD_WAIT;
                    end
                end
            end
            ST_PD_WAIT: begin
                sel = FT_STATUS;
                if (load && i_pd_ack) begin
                    state_d = ST_PD_IDLE;
                end
            end
            ST_PD_IDLE: begin
                sel = FT_IDLE;
                if (load && !i_pd_req) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                sel     = FT_ALIGN;
                state_d = ST_INIT;
            end
        endcase
    end

    // Payload for the selected frame type.
    always_comb begin
        payload = 64'h0;
        unique case (sel)
            FT_ALIGN:  payload = ALIGN_WORD;
            FT_STATUS: payload = status_payload(status_now);
            FT_DATA:   payload = i_data;
            default:   payload = 64'h0;
        endcase
    end

    // Pending STATUS: latched on change or repeat timeout, dropped when sent.
    always_comb begin
        pending_d = pending_q;
        if (load) begin
            if (sel == FT_STATUS) begin
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q || status_diff || status_due;
            end
        end
    end

    assign enter_active = (state_q == ST_INIT) && (state_d == ST_ACTIVE);
    assign align_clr    = enter_active || (load && (sel == FT_ALIGN));
    assign status_clr   = enter_active || (load && (sel == FT_STATUS));
    assign cnt_inc      = load && (state_q == ST_ACTIVE);

    qeciphy_period_counter #(
        .PERIOD (ALIGN_PERIOD)
    ) u_align_cnt (
        .clk_i   (tx_clk),
        .rst_i   (tx_rst),
        .clear_i (align_clr),
        .inc_i   (cnt_inc),
        .due_o   (align_due)
    );

    qeciphy_period_counter #(
        .PERIOD (STATUS_REPEAT)
    ) u_status_cnt (
        .clk_i   (tx_clk),
        .rst_i   (tx_rst),
        .clear_i (status_clr),
        .inc_i   (cnt_inc),
        .due_o   (status_due)
    );

    // State, output frame register and last-sent status triple.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q   <= ST_INIT;
            allow_q   <= 1'b0;
            valid_q   <= 1'b0;
            type_q    <= FT_IDLE;
            data_q    <= 64'h0;
            last_q    <= 3'b000;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            allow_q   <= (state_d == ST_ACTIVE);
            pending_q <= pending_d;
            if (load) begin
                valid_q <= 1'b1;
                type_q  <= sel;
                data_q  <= payload;
                if (sel == FT_STATUS) begin
                    last_q <= status_now;
                end
            end
        end
    end

    assign o_ready         = !tx_rst && load && (sel == FT_DATA);
    assign o_allow_user_tx = allow_q;
    assign o_frame_data    = data_q;
    assign o_frame_type    = type_q;
    assign o_frame_valid   = valid_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_qeciphy_tx_scheduler.sv
// Directed bench for the QECIPHY TX frame scheduler with a FIFO model and an
// expected-word queue for user data.
module tb_qeciphy_tx_scheduler;
    import qeciphy_pkg::*;

    localparam int AP = 8;
    localparam int SR = 16;

    // ---------------- clock / reset ----------------
    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic        i_rx_rdy;
    logic        i_remote_rx_rdy;
    logic        i_pd_req;
    logic        i_pd_ack;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_allow_user_tx;
    logic [63:0] o_frame_data;
    logic [1:0]  o_frame_type;
    logic        o_frame_valid;
    logic        i_frame_ready;
    logic [1:0]  o_dbg_state;

    always #5 tx_clk = ~tx_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    qeciphy_tx_scheduler #(
        .ALIGN_PERIOD  (AP),
        .STATUS_REPEAT (SR)
    ) dut (
        .tx_clk          (tx_clk),
        .tx_rst          (tx_rst),
        .i_rx_rdy        (i_rx_rdy),
        .i_remote_rx_rdy (i_remote_rx_rdy),
        .i_pd_req        (i_pd_req),
        .i_pd_ack        (i_pd_ack),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .o_allow_user_tx (o_allow_user_tx),
        .o_frame_data    (o_frame_data),
        .o_frame_type    (o_frame_type),
        .o_frame_valid   (o_frame_valid),
        .i_frame_ready   (i_frame_ready),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    bit gap_on     = 1'b0;
    bit seen_align = 1'b0;
    int gap        = 0;
    int n_gaps     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [1:0] t, input logic [63:0] d);
        check({tag, "_type"}, 64'(o_frame_type), 64'(t));
        check({tag, "_data"}, o_frame_data, d);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_fifo();
        i_valid = (fifo_q.size() != 0);
        i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
    endtask

    // One clock: FIFO pops follow o_ready, accepted DATA frames are matched
    // against popped words, ALIGN spacing is measured in accepted frames.
    task automatic step();
        logic        acc;
        logic        pop;
        logic [1:0]  acc_t;
        logic [63:0] acc_d;
        logic [63:0] pop_d;
        #1;
        acc   = !tx_rst && o_frame_valid && i_frame_ready;
        acc_t = o_frame_type;
        acc_d = o_frame_data;
        pop   = !tx_rst && i_valid && o_ready;
        pop_d = i_data;
        @(posedge tx_clk);
        #1;
        if (pop) begin
            exp_q.push_back(pop_d);
            void'(fifo_q.pop_front());
        end
        if (acc && acc_t == FT_DATA) begin
            if (exp_q.size() == 0) begin
                check("sb_underrun", 64'(exp_q.size()), 64'd1);
            end else begin
                check("sb_word", acc_d, exp_q.pop_front());
            end
        end
        if (acc && gap_on) begin
            if (acc_t == FT_ALIGN) begin
                if (seen_align) begin
                    check("align_gap", 64'(gap), 64'(AP - 1));
                    n_gaps++;
                end
                seen_align = 1'b1;
                gap        = 0;
            end else begin
                gap++;
            end
        end
        drive_fifo();
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0]  p2_t[12];
    logic [63:0] p2_d[12];

    initial begin
        tx_rst          = 1'b1;
        i_rx_rdy        = 1'b0;
        i_remote_rx_rdy = 1'b0;
        i_pd_req        = 1'b0;
        i_pd_ack        = 1'b0;
        i_data          = 64'h0;
        i_valid         = 1'b0;
        i_frame_ready   = 1'b1;

        repeat (3) @(posedge tx_clk);
        #1;
        check("rst_valid", 64'(o_frame_valid), 64'd0);
        check("rst_data", o_frame_data, 64'h0);
        check("rst_type", 64'(o_frame_type), 64'(FT_IDLE));
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_allow", 64'(o_allow_user_tx), 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'(ST_INIT));

        // Links down, user words waiting: ALIGN only, nothing popped.
        tx_rst = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(64'(i));
        drive_fifo();
        for (int i = 0; i < 20; i++) begin
            step();
            check_frame("init_align", FT_ALIGN, ALIGN_WORD);
            check("init_valid", 64'(o_frame_valid), 64'd1);
            check("init_allow", 64'(o_allow_user_tx), 64'd0);
            check("init_ready", 64'(o_ready), 64'd0);
        end

        // Bring-up: entry ALIGN, STATUS for rx_rdy, data with forced ALIGN.
        p2_t = '{FT_ALIGN, FT_STATUS, FT_DATA, FT_DATA, FT_DATA, FT_DATA,
                 FT_DATA, FT_DATA, FT_ALIGN, FT_DATA, FT_DATA, FT_IDLE};
        p2_d = '{ALIGN_WORD, 64'h1, 64'h1, 64'h2, 64'h3, 64'h4,
                 64'h5, 64'h6, ALIGN_WORD, 64'h7, 64'h8, 64'h0};
        i_rx_rdy        = 1'b1;
        i_remote_rx_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_frame("up_seq", p2_t[i], p2_d[i]);
            if (i == 0) begin
                check("up_allow", 64'(o_allow_user_tx), 64'd1);
                check("up_state", 64'(o_dbg_state), 64'(ST_ACTIVE));
            end
        end

        // Continuous traffic: ALIGN after every AP-1 accepted frames.
        gap_on     = 1'b1;
        seen_align = 1'b0;
        gap        = 0;
        n_gaps     = 0;
        for (int i = 0; i < 24; i++) fifo_q.push_back(64'h100 + 64'(i));
        drive_fifo();
        for (int c = 0; c < 200; c++) begin
            step();
            if (fifo_q.size() == 0 && exp_q.size() == 0) break;
        end
        check("burst_fifo_left", 64'(fifo_q.size()), 64'd0);
        check("burst_sb_left", 64'(exp_q.size()), 64'd0);
        check("burst_align_seen", 64'(n_gaps >= 3), 64'd1);

        // Random encoder back-pressure.
        for (int i = 0; i < 16; i++) fifo_q.push_back(64'h200 + 64'(i));
        drive_fifo();
        for (int c = 0; c < 400; c++) begin
            i_frame_ready = 1'($urandom_range(0, 1));
            step();
            if (fifo_q.size() == 0 && exp_q.size() == 0) break;
        end
        i_frame_ready = 1'b1;
        check("bp_fifo_left", 64'(fifo_q.size()), 64'd0);
        check("bp_sb_left", 64'(exp_q.size()), 64'd0);
        gap_on = 1'b0;

        // Power-down request and acknowledge.
        i_pd_req = 1'b1;
        step();
        check_frame("pd_enter", FT_STATUS, 64'h3);
        check("pd_allow", 64'(o_allow_user_tx), 64'd0);
        check("pd_state", 64'(o_dbg_state), 64'(ST_PD_WAIT));
        fifo_q.push_back(64'hDEAD);
        drive_fifo();
        #1;
        check("pd_no_pop", 64'(o_ready), 64'd0);
        step();
        check_frame("pd_repeat", FT_STATUS, 64'h3);
        check("pd_no_pop2", 64'(o_ready), 64'd0);
        i_pd_ack = 1'b1;
        step();
        check_frame("pd_ack", FT_STATUS, 64'h7);
        step();
        check_frame("pd_idle", FT_IDLE, 64'h0);
        check("pd_idle_state", 64'(o_dbg_state), 64'(ST_PD_IDLE));
        i_pd_req = 1'b0;
        i_pd_ack = 1'b0;
        step();
        check_frame("pd_exit", FT_IDLE, 64'h0);
        check("pd_exit_state", 64'(o_dbg_state), 64'(ST_INIT));
        step();
        check_frame("pd_realign", FT_ALIGN, ALIGN_WORD);
        check("pd_realign_allow", 64'(o_allow_user_tx), 64'd1);

        // Re-entry, then STATUS and ALIGN due in the same slot.
        step();
        check_frame("re_status", FT_STATUS, 64'h1);
        check("re_ready", 64'(o_ready), 64'd1);
        step();
        check_frame("re_data", FT_DATA, 64'hDEAD);
        for (int i = 0; i < 5; i++) begin
            step();
            check_frame("re_idle", FT_IDLE, 64'h0);
        end
        i_pd_ack = 1'b1;
        step();
        check_frame("clash_status", FT_STATUS, 64'h5);
        step();
        check_frame("clash_align", FT_ALIGN, ALIGN_WORD);
        step();
        check_frame("clash_idle", FT_IDLE, 64'h0);
        check("clash_state", 64'(o_dbg_state), 64'(ST_ACTIVE));
        i_pd_ack = 1'b0;
        step();
        check_frame("ack_drop", FT_STATUS, 64'h1);

        // Link drop mid-burst.
        for (int i = 0; i < 10; i++) fifo_q.push_back(64'h300 + 64'(i));
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            step();
            check_frame("drop_pre", FT_DATA, 64'h300 + 64'(i));
        end
        i_remote_rx_rdy = 1'b0;
        #1;
        check("drop_ready", 64'(o_ready), 64'd0);
        step();
        check_frame("drop_align", FT_ALIGN, ALIGN_WORD);
        check("drop_allow", 64'(o_allow_user_tx), 64'd0);
        check("drop_state", 64'(o_dbg_state), 64'(ST_INIT));
        for (int i = 0; i < 2; i++) begin
            step();
            check_frame("drop_hold", FT_ALIGN, ALIGN_WORD);
            check("drop_ready2", 64'(o_ready), 64'd0);
        end
        check("drop_fifo", 64'(fifo_q.size()), 64'd7);
        check("drop_sb", 64'(exp_q.size()), 64'd0);

        // Reset while the output frame is stalled.
        i_frame_ready = 1'b0;
        step();
        check_frame("stall_hold", FT_ALIGN, ALIGN_WORD);
        tx_rst = 1'b1;
        step();
        check("mrst_valid", 64'(o_frame_valid), 64'd0);
        check("mrst_data", o_frame_data, 64'h0);
        check("mrst_type", 64'(o_frame_type), 64'(FT_IDLE));
        check("mrst_allow", 64'(o_allow_user_tx), 64'd0);
        check("mrst_ready", 64'(o_ready), 64'd0);
        check("mrst_state", 64'(o_dbg_state), 64'(ST_INIT));

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
